dmem_access_controller: RTL and testbench
=========================================

# dmem_access_controller

Sequencer for the data-memory port of the RV32I MEM stage. Accepts the load/store control fields decoded for the current instruction (read/write strobe, load/store funct3) plus the ALU-computed address and rs2 store data. Runs a req/ack transaction against the data memory, stalling the pipeline until completion. Generates byte enables and lane-replicated store data, returns the aligned and extended load result, and flags misaligned, illegal and timed-out accesses.

## Interface
- NB_WORD, 32, data word width
- NB_ADDR, 32, byte address width
- TIMEOUT, 16, maximum REQ cycles without ack before fault (≥1)

- i_clock  in  1  system clock, rising edge
- i_reset_n  in  1  asynchronous, active-low reset
- i_valid  in  1  MEM stage holds a valid instruction
- i_dmem_rd  in  1  load strobe from control bus
- i_dmem_wr  in  1  store strobe from control bus
- i_ld_st_funct3  in  3  access size/sign (funct3)
- i_addr  in  NB_ADDR  byte address (ALU result)
- i_store_data  in  NB_WORD  rs2 value
- o_stall  out  1  hold pipeline
- o_load_valid  out  1  one-cycle pulse, o_load_data valid
- o_load_data  out  NB_WORD  aligned, extended load result
- o_fault  out  1  one-cycle pulse, access aborted
- o_fault_cause  out  2  fault_cause_t, valid with o_fault
- o_mem_req  out  1  memory request
- o_mem_we  out  1  1 = write
- o_mem_addr  out  NB_ADDR  word-aligned address ({i_addr[NB_ADDR-1:2],2'b00})
- o_mem_be  out  4  byte enables
- o_mem_wdata  out  NB_WORD  lane-replicated store data
- i_mem_ack  in  1  memory completion
- i_mem_rdata  in  NB_WORD  read word, valid with ack

## Operation
- States: IDLE, REQ, DONE.
- Access = i_valid & (i_dmem_rd | i_dmem_wr).
- IDLE:
  - No access -> stay; o_stall=0.
  - Access -> o_stall=1 (combinational). Capture address, funct3, direction, store data and be into registers.
  - Legal access -> REQ. Fault check failed -> DONE with the fault recorded.
- Fault check, in priority order:
  - ILLEGAL: rd&wr both set; load funct3 ∈ {3,6,7}; store funct3 ≥ 3.
  - MISALIGNED: halfword with addr[0]=1; word with addr[1:0]≠0.
- REQ:
  - o_mem_req=1 and o_stall=1. Address, we, be and wdata are held stable.
  - Timeout counter increments each REQ cycle.
  - Ack sampled high -> DONE; load data is extracted from i_mem_rdata and registered.
  - Counter reaches TIMEOUT without ack -> DONE with TIMEOUT fault; req drops.
- DONE:
  - Exactly one cycle; o_stall=0.
  - o_load_valid=1 only for a successful load. o_fault=1 if a fault was recorded.
  - Always -> IDLE.
- Byte enables:
  - SB: 4'b0001<<addr[1:0], wdata={4{data[7:0]}}.
  - SH: 4'b0011<<addr[1:0], wdata={2{data[15:0]}}.
  - SW: 4'b1111, wdata unchanged.
- Load extract:
  - Shift rdata right by 8*addr[1:0].
  - LB/LH sign-extend bit 7/15; LBU/LHU zero-extend; LW passes through.
- Once in REQ, the transaction completes even if i_valid drops (flush). Stores are never cancelled.
- i_mem_ack outside REQ is ignored.

## Timing
- Reset (async assert): state=IDLE, counter=0, all outputs 0. o_mem_req drops immediately, no o_load_valid; memory abandons any transaction.
- All o_mem_*, o_load_data, o_load_valid, o_fault, o_fault_cause are registered or decoded from state. o_stall is combinational.
- Zero-wait memory (ack in first REQ cycle): stall 2 cycles (IDLE, REQ); DONE in cycle 3.
- N wait cycles add N stall cycles.
- Fault detected in IDLE: 1 stall cycle, then DONE with o_fault.
- Timeout: TIMEOUT REQ cycles, then DONE.
- Ack in the same cycle the counter hits TIMEOUT: ack wins, no fault.
- Back-to-back accesses: the next instruction is seen in IDLE the cycle after DONE.

## Structure
- riscv_defs additions:
  - fault_cause_t (NONE=0, MISALIGNED=1, ILLEGAL=2, TIMEOUT=3).
  - dmem_state_t.
  - funct3 constants LB, LH, LW, LBU, LHU, SB, SH, SW.
- Sub-module dmem_lane_align (combinational): store be/wdata generation and load shift/extend. Reused by the verification reference model.

## Test plan
- SW to 0x100, data 0xDEADBEEF, ack in first REQ cycle -> be=4'b1111, addr=0x100, we=1; stall 2 cycles; no fault.
- LB from 0x203, rdata=0x80FF_0000, 3 wait cycles -> be=4'b1000, o_load_data=0xFFFF_FF80, load_valid in DONE; stall 5 cycles.
- LHU from 0x002, rdata=0xBEEF_1234 -> 0x0000_BEEF. SH 0xABCD to 0x002 -> be=4'b1100, wdata=0xABCD_ABCD.
- LW from 0x101 -> no o_mem_req, o_fault=1, cause=MISALIGNED, 1 stall cycle. Load funct3=7 -> cause=ILLEGAL.
- TIMEOUT=4, no ack -> req high 4 cycles, then fault=TIMEOUT. Repeat with ack on the 4th cycle -> success, no fault.
- Reset asserted mid-REQ -> req low asynchronously, all outputs 0. After release, a new LW completes normally.

Source files
------------

// File: rtl/dmem_access_controller_pkg.sv
// Shared types for the MEM-stage data-memory sequencer: fault causes, FSM states,
// load/store funct3 encodings and the access legality checks.
package dmem_access_controller_pkg;

    typedef enum logic [1:0] {
        FC_NONE       = 2'd0,
        FC_MISALIGNED = 2'd1,
        FC_ILLEGAL    = 2'd2,
        FC_TIMEOUT    = 2'd3
    } fault_cause_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } dmem_state_t;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;
    localparam logic [2:0] F3_SB  = 3'd0;
    localparam logic [2:0] F3_SH  = 3'd1;
    localparam logic [2:0] F3_SW  = 3'd2;

    function automatic logic access_illegal(input logic rd, input logic wr, input logic [2:0] f3);
        logic w_bad_ld;
        w_bad_ld = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
        return (rd && wr) || (rd && w_bad_ld) || (wr && (f3 >= 3'd3));
    endfunction

    // Size lives in funct3[1:0]; the unsigned load variants share the signed alignment rule.
    function automatic logic access_misaligned(input logic [2:0] f3, input logic [1:0] off);
        return ((f3[1:0] == F3_LH[1:0]) && off[0]) ||
               ((f3[1:0] == F3_LW[1:0]) && (off != 2'b00));
    endfunction

endpackage

// File: rtl/dmem_access_controller_if.sv
// Data-memory req/ack bus; master is the MEM-stage controller, slave the memory.
interface dmem_access_controller_if #(
    parameter int NB_WORD = 32,
    parameter int NB_ADDR = 32
);
    logic                 o_mem_req;
    logic                 o_mem_we;
    logic [NB_ADDR-1:0]   o_mem_addr;
    logic [NB_WORD/8-1:0] o_mem_be;
    logic [NB_WORD-1:0]   o_mem_wdata;
    logic                 i_mem_ack;
    logic [NB_WORD-1:0]   i_mem_rdata;

    modport master (
        output o_mem_req, o_mem_we, o_mem_addr, o_mem_be, o_mem_wdata,
        input  i_mem_ack, i_mem_rdata
    );

    modport slave (
        input  o_mem_req, o_mem_we, o_mem_addr, o_mem_be, o_mem_wdata,
        output i_mem_ack, i_mem_rdata
    );
endinterface

// File: rtl/dmem_access_controller_lane_align.sv
// Combinational byte-lane steering: store byte enables / replicated write data,
// and load shift plus sign/zero extension.
module dmem_access_controller_lane_align
    import dmem_access_controller_pkg::*;
#(
    parameter int NB_WORD   = 32,
    parameter int NUM_LANES = NB_WORD / 8
) (
    input  logic [2:0]           i_funct3,
    input  logic [1:0]           i_off,
    input  logic [NB_WORD-1:0]   i_store_data,
    input  logic [NB_WORD-1:0]   i_rdata,
    output logic [NUM_LANES-1:0] o_be,
    output logic [NB_WORD-1:0]   o_wdata,
    output logic [NB_WORD-1:0]   o_load_data
);
    logic [NB_WORD-1:0] w_shift;

    always_comb begin
        o_be = '0;
        case (i_funct3[1:0])
            F3_SB[1:0]: o_be = NUM_LANES'(1) << i_off;
            F3_SH[1:0]: o_be = NUM_LANES'(3) << i_off;
            F3_SW[1:0]: o_be = '1;
            default:    o_be = '0;
        endcase
    end

    // Each byte lane picks the source byte that lands on it for the access size.
    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        assign o_wdata[8*k +: 8] =
            (i_funct3[1:0] == F3_SB[1:0]) ? i_store_data[7:0] :
            (i_funct3[1:0] == F3_SH[1:0]) ? i_store_data[8*(k%2) +: 8] :
                                            i_store_data[8*k +: 8];
    end

    assign w_shift = i_rdata >> {i_off, 3'b000};

    always_comb begin
        o_load_data = w_shift;
        case (i_funct3)
            F3_LB:   o_load_data = {{(NB_WORD-8){w_shift[7]}}, w_shift[7:0]};
            F3_LH:   o_load_data = {{(NB_WORD-16){w_shift[15]}}, w_shift[15:0]};
            F3_LBU:  o_load_data = {{(NB_WORD-8){1'b0}}, w_shift[7:0]};
            F3_LHU:  o_load_data = {{(NB_WORD-16){1'b0}}, w_shift[15:0]};
            default: o_load_data = w_shift;
        endcase
    end
endmodule

// File: rtl/dmem_access_controller.sv
// MEM-stage data-memory sequencer: IDLE -> REQ -> DONE req/ack transaction with
// pipeline stall, lane alignment, and misaligned/illegal/timeout fault reporting.
module dmem_access_controller
    import dmem_access_controller_pkg::*;
#(
    parameter int NB_WORD = 32,
    parameter int NB_ADDR = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                 i_clock,
    input  logic                 i_reset_n,
    input  logic                 i_valid,
    input  logic                 i_dmem_rd,
    input  logic                 i_dmem_wr,
    input  logic [2:0]           i_ld_st_funct3,
    input  logic [NB_ADDR-1:0]   i_addr,
    input  logic [NB_WORD-1:0]   i_store_data,
    output logic                 o_stall,
    output logic                 o_load_valid,
    output logic [NB_WORD-1:0]   o_load_data,
    output logic                 o_fault,
    output fault_cause_t         o_fault_cause,
    dmem_access_controller_if.master mem
);
    localparam int NUM_LANES = NB_WORD / 8;
    localparam int CNT_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    dmem_state_t            r_state, w_nxt;
    logic [NB_ADDR-1:0]     r_addr;
    logic [1:0]             r_off;
    logic [2:0]             r_f3;
    logic                   r_we, r_is_load, r_fault;
    fault_cause_t           r_cause;
    logic [NUM_LANES-1:0]   r_be;
    logic [NB_WORD-1:0]     r_wdata, r_load_data;
    logic [CNT_W-1:0]       r_cnt;

    logic                   w_access, w_illegal, w_misal;
    logic                   w_capture, w_ack_take, w_tmo, w_stall;
    logic [2:0]             w_f3;
    logic [1:0]             w_off;
    logic [NUM_LANES-1:0]   w_be;
    logic [NB_WORD-1:0]     w_wdata, w_ld;

    assign w_access  = i_valid && (i_dmem_rd || i_dmem_wr);
    assign w_illegal = access_illegal(i_dmem_rd, i_dmem_wr, i_ld_st_funct3);
    assign w_misal   = access_misaligned(i_ld_st_funct3, i_addr[1:0]);

    // One aligner serves both directions: live inputs while capturing in IDLE,
    // the held access fields while waiting for the read data.
    assign w_f3  = (r_state == ST_IDLE) ? i_ld_st_funct3 : r_f3;
    assign w_off = (r_state == ST_IDLE) ? i_addr[1:0]    : r_off;

    dmem_access_controller_lane_align #(.NB_WORD(NB_WORD), .NUM_LANES(NUM_LANES)) u_align (
        .i_funct3    (w_f3),
        .i_off       (w_off),
        .i_store_data(i_store_data),
        .i_rdata     (mem.i_mem_rdata),
        .o_be        (w_be),
        .o_wdata     (w_wdata),
        .o_load_data (w_ld)
    );

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) r_state <= ST_IDLE;
        else            r_state <= w_nxt;
    end

    always_comb begin
        w_nxt      = r_state;
        w_capture  = 1'b0;
        w_ack_take = 1'b0;
        w_tmo      = 1'b0;
        w_stall    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_access) begin
                    w_stall   = 1'b1;
                    w_capture = 1'b1;
                    w_nxt     = (w_illegal || w_misal) ? ST_DONE : ST_REQ;
                end
            end
            ST_REQ: begin
                w_stall = 1'b1;
                if (mem.i_mem_ack) begin
                    w_ack_take = 1'b1;
                    w_nxt      = ST_DONE;
                end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                    w_tmo = 1'b1;
                    w_nxt = ST_DONE;
                end
            end
            ST_DONE: w_nxt = ST_IDLE;
            default: w_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_addr      <= '0;
            r_off       <= '0;
            r_f3        <= '0;
            r_we        <= 1'b0;
            r_is_load   <= 1'b0;
            r_be        <= '0;
            r_wdata     <= '0;
            r_fault     <= 1'b0;
            r_cause     <= FC_NONE;
            r_cnt       <= '0;
            r_load_data <= '0;
        end else begin
            if (w_capture) begin
                r_addr    <= {i_addr[NB_ADDR-1:2], 2'b00};
                r_off     <= i_addr[1:0];
                r_f3      <= i_ld_st_funct3;
                r_we      <= i_dmem_wr;
                r_is_load <= i_dmem_rd && !i_dmem_wr;
                r_be      <= w_be;
                r_wdata   <= w_wdata;
                r_fault   <= w_illegal || w_misal;
                r_cause   <= w_illegal ? FC_ILLEGAL : (w_misal ? FC_MISALIGNED : FC_NONE);
                r_cnt     <= '0;
            end
            if (w_tmo) begin
                r_fault <= 1'b1;
                r_cause <= FC_TIMEOUT;
            end else if ((r_state == ST_REQ) && !w_ack_take) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_ack_take && r_is_load) r_load_data <= w_ld;
        end
    end

    // Gated by reset so the stall request also reads 0 while reset is held.
    assign o_stall       = w_stall && i_reset_n;
    assign o_load_valid  = (r_state == ST_DONE) && r_is_load && !r_fault;
    assign o_fault       = (r_state == ST_DONE) && r_fault;
    assign o_fault_cause = (r_state == ST_DONE) ? r_cause : FC_NONE;
    assign o_load_data   = r_load_data;

    assign mem.o_mem_req   = (r_state == ST_REQ);
    assign mem.o_mem_we    = r_we;
    assign mem.o_mem_addr  = r_addr;
    assign mem.o_mem_be    = r_be;
    assign mem.o_mem_wdata = r_wdata;
endmodule

// File: tb/tb_dmem_access_controller.sv
// Bench for dmem_access_controller: table of accesses driven against a scripted
// memory responder, expected results queued at drive time and checked at DONE.
module tb_dmem_access_controller;
    import dmem_access_controller_pkg::*;

    logic        i_clock = 1'b0;
    logic        i_reset_n;
    logic        i_valid, i_dmem_rd, i_dmem_wr;
    logic [2:0]  i_ld_st_funct3;
    logic [31:0] i_addr, i_store_data;
    logic        o_stall, o_load_valid, o_fault;
    logic [31:0] o_load_data;
    fault_cause_t o_fault_cause;

    dmem_access_controller_if #(.NB_WORD(32), .NB_ADDR(32)) mem_if ();

    dmem_access_controller #(.NB_WORD(32), .NB_ADDR(32), .TIMEOUT(4)) dut (
        .i_clock       (i_clock),
        .i_reset_n     (i_reset_n),
        .i_valid       (i_valid),
        .i_dmem_rd     (i_dmem_rd),
        .i_dmem_wr     (i_dmem_wr),
        .i_ld_st_funct3(i_ld_st_funct3),
        .i_addr        (i_addr),
        .i_store_data  (i_store_data),
        .o_stall       (o_stall),
        .o_load_valid  (o_load_valid),
        .o_load_data   (o_load_data),
        .o_fault       (o_fault),
        .o_fault_cause (o_fault_cause),
        .mem           (mem_if.master)
    );

    always #5 i_clock = ~i_clock;

    typedef struct {
        logic        rd, wr;
        logic [2:0]  f3;
        logic [31:0] addr, sdata, rdata;
        int          waits;   // REQ cycles before ack; -1 = never ack
        bit          flush;   // drop i_valid once REQ is reached
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata, ldata;
        logic        lv, flt;
        logic [1:0]  cause;
        int          stalls, reqs;
    } vec_t;

    vec_t vecs[16];
    vec_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        vec_t e;
        int   stalls = 0;
        int   reqs = 0;
        bit   done = 0;
        @(negedge i_clock);
        i_valid = 1'b1; i_dmem_rd = v.rd; i_dmem_wr = v.wr;
        i_ld_st_funct3 = v.f3; i_addr = v.addr; i_store_data = v.sdata;
        exp_q.push_back(v);
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            #1;
            if (o_stall) stalls++;
            if (mem_if.o_mem_req) begin
                reqs++;
                chk({nm, ".addr"}, mem_if.o_mem_addr, {v.addr[31:2], 2'b00});
                chk({nm, ".be"}, {28'd0, mem_if.o_mem_be}, {28'd0, v.be});
                chk({nm, ".we"}, {31'd0, mem_if.o_mem_we}, {31'd0, v.we});
                if (v.wr) chk({nm, ".wdata"}, mem_if.o_mem_wdata, v.wdata);
                if (v.flush && reqs == 1) begin
                    i_valid = 1'b0; i_addr = $urandom; i_ld_st_funct3 = 3'd7; i_store_data = $urandom;
                end
                if (v.waits >= 0 && reqs > v.waits) begin
                    mem_if.i_mem_ack = 1'b1; mem_if.i_mem_rdata = v.rdata;
                end else begin
                    mem_if.i_mem_ack = 1'b0; mem_if.i_mem_rdata = $urandom;
                end
            end else begin
                mem_if.i_mem_ack = 1'b0;
                if (cyc > 0 && !o_stall) begin
                    done = 1;
                    e = exp_q.pop_front();
                    chk({nm, ".load_valid"}, {31'd0, o_load_valid}, {31'd0, e.lv});
                    chk({nm, ".fault"}, {31'd0, o_fault}, {31'd0, e.flt});
                    if (e.flt) chk({nm, ".cause"}, {30'd0, o_fault_cause}, {30'd0, e.cause});
                    if (e.lv) chk({nm, ".load_data"}, o_load_data, e.ldata);
                    chk({nm, ".stalls"}, stalls, e.stalls);
                    chk({nm, ".reqs"}, reqs, e.reqs);
                end
            end
            if (!done) @(negedge i_clock);
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL %s.done: no DONE within 40 cycles, stalls %0d reqs %0d", nm, stalls, reqs);
            void'(exp_q.pop_front());
        end
    endtask

    task automatic chk_quiet(input string nm);
        chk({nm, ".stall"}, {31'd0, o_stall}, 32'd0);
        chk({nm, ".req"}, {31'd0, mem_if.o_mem_req}, 32'd0);
        chk({nm, ".load_valid"}, {31'd0, o_load_valid}, 32'd0);
        chk({nm, ".fault"}, {31'd0, o_fault}, 32'd0);
        chk({nm, ".cause"}, {30'd0, o_fault_cause}, 32'd0);
    endtask

    task automatic chk_reset_outs(input string nm);
        chk_quiet(nm);
        chk({nm, ".we"}, {31'd0, mem_if.o_mem_we}, 32'd0);
        chk({nm, ".be"}, {28'd0, mem_if.o_mem_be}, 32'd0);
        chk({nm, ".addr"}, mem_if.o_mem_addr, 32'd0);
        chk({nm, ".wdata"}, mem_if.o_mem_wdata, 32'd0);
        chk({nm, ".load_data"}, o_load_data, 32'd0);
    endtask

    initial begin
        vec_t rv;
        //          rd wr f3   addr       sdata         rdata        wt  fl be    we wdata         ldata         lv flt cause st rq
        vecs[0]  = '{0, 1, 3'd2, 32'h100, 32'hDEADBEEF, 32'h0,        0, 0, 4'hF, 1, 32'hDEADBEEF, 32'h0,        0, 0, 2'd0, 2, 1};
        vecs[1]  = '{1, 0, 3'd0, 32'h203, 32'h0,        32'h80FF0000, 3, 0, 4'h8, 0, 32'h0,        32'hFFFFFF80, 1, 0, 2'd0, 5, 4};
        vecs[2]  = '{1, 0, 3'd5, 32'h002, 32'h0,        32'hBEEF1234, 0, 0, 4'hC, 0, 32'h0,        32'h0000BEEF, 1, 0, 2'd0, 2, 1};
        vecs[3]  = '{0, 1, 3'd1, 32'h002, 32'h1234ABCD, 32'h0,        1, 0, 4'hC, 1, 32'hABCDABCD, 32'h0,        0, 0, 2'd0, 3, 2};
        vecs[4]  = '{1, 0, 3'd2, 32'h101, 32'h0,        32'h0,        0, 0, 4'h0, 0, 32'h0,        32'h0,        0, 1, 2'd1, 1, 0};
        vecs[5]  = '{1, 0, 3'd7, 32'h100, 32'h0,        32'h0,        0, 0, 4'h0, 0, 32'h0,        32'h0,        0, 1, 2'd2, 1, 0};
        vecs[6]  = '{1, 0, 3'd2, 32'h104, 32'h0,        32'h0,       -1, 0, 4'hF, 0, 32'h0,        32'h0,        0, 1, 2'd3, 5, 4};
        vecs[7]  = '{1, 0, 3'd2, 32'h108, 32'h0,        32'h12345678, 3, 0, 4'hF, 0, 32'h0,        32'h12345678, 1, 0, 2'd0, 5, 4};
        vecs[8]  = '{0, 1, 3'd0, 32'h0C1, 32'h1111115A, 32'h0,        2, 0, 4'h2, 1, 32'h5A5A5A5A, 32'h0,        0, 0, 2'd0, 4, 3};
        vecs[9]  = '{1, 0, 3'd1, 32'h006, 32'h0,        32'h80017FFF, 0, 0, 4'hC, 0, 32'h0,        32'hFFFF8001, 1, 0, 2'd0, 2, 1};
        vecs[10] = '{1, 1, 3'd2, 32'h101, 32'h0,        32'h0,        0, 0, 4'h0, 0, 32'h0,        32'h0,        0, 1, 2'd2, 1, 0};
        vecs[11] = '{0, 1, 3'd3, 32'h100, 32'h0,        32'h0,        0, 0, 4'h0, 0, 32'h0,        32'h0,        0, 1, 2'd2, 1, 0};
        vecs[12] = '{1, 0, 3'd4, 32'h001, 32'h0,        32'h0000F200, 0, 0, 4'h2, 0, 32'h0,        32'h000000F2, 1, 0, 2'd0, 2, 1};
        vecs[13] = '{0, 1, 3'd1, 32'h003, 32'h0,        32'h0,        0, 0, 4'h0, 0, 32'h0,        32'h0,        0, 1, 2'd1, 1, 0};
        vecs[14] = '{1, 0, 3'd2, 32'h10C, 32'h0,        32'hCAFEF00D, 2, 1, 4'hF, 0, 32'h0,        32'hCAFEF00D, 1, 0, 2'd0, 4, 3};
        vecs[15] = '{0, 1, 3'd2, 32'h1F8, 32'h01234567, 32'h0,        1, 0, 4'hF, 1, 32'h01234567, 32'h0,        0, 0, 2'd0, 3, 2};

        i_reset_n = 1'b0; i_valid = 1'b0; i_dmem_rd = 1'b0; i_dmem_wr = 1'b0;
        i_ld_st_funct3 = 3'd0; i_addr = 32'd0; i_store_data = 32'd0;
        mem_if.i_mem_ack = 1'b0; mem_if.i_mem_rdata = 32'd0;
        repeat (2) @(negedge i_clock);
        #1 chk_reset_outs("reset");
        @(negedge i_clock);
        i_reset_n = 1'b1;

        // Ack while no transaction is outstanding must be ignored.
        mem_if.i_mem_ack = 1'b1; mem_if.i_mem_rdata = 32'h5555AAAA;
        for (int i = 0; i < 3; i++) begin
            @(negedge i_clock);
            #1 chk_quiet($sformatf("stray_ack%0d", i));
        end
        mem_if.i_mem_ack = 1'b0;

        // Back-to-back: each access is presented in the IDLE cycle after the previous DONE.
        for (int i = 0; i < 16; i++) run_vec(vecs[i], $sformatf("vec%0d", i));
        chk("scoreboard_empty", exp_q.size(), 32'd0);

        // Reset asserted in the middle of an unacknowledged read.
        @(negedge i_clock);
        i_valid = 1'b1; i_dmem_rd = 1'b1; i_dmem_wr = 1'b0;
        i_ld_st_funct3 = 3'd2; i_addr = 32'h110;
        mem_if.i_mem_ack = 1'b0;
        repeat (2) @(negedge i_clock);
        #1 chk("midreq.req_before", {31'd0, mem_if.o_mem_req}, 32'd1);
        #1 i_reset_n = 1'b0;
        #1 chk_reset_outs("midreq");
        @(negedge i_clock);
        i_valid = 1'b0; i_dmem_rd = 1'b0;
        #1 chk_reset_outs("midreq_held");
        @(negedge i_clock);
        i_reset_n = 1'b1;
        rv = '{1, 0, 3'd2, 32'h110, 32'h0, 32'h0BADF00D, 1, 0, 4'hF, 0, 32'h0, 32'h0BADF00D, 1, 0, 2'd0, 3, 2};
        run_vec(rv, "after_reset");
        @(negedge i_clock);
        i_valid = 1'b0;
        #1 chk_quiet("final_idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
